// File: rtl/traffic_timer.sv
// Per-light duration timer that pairs with the traffic light FSM: a prescaler
// divides clk down to seconds, and a seconds counter runs down the current light.
module traffic_timer #(
  parameter int LIGHT_STATE_WIDTH = 3,
  parameter int CLK_PER_SEC       = 50,
  parameter int GREEN_SEC         = 30,
  parameter int YELLOW_SEC        = 3,
  parameter int RED_SEC           = 30,
  parameter int CNT_WIDTH         = 8,
  parameter int PRE_WIDTH         = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [LIGHT_STATE_WIDTH-1:0] light_cnt_init,
  output logic                         second_cnt_pre_last,
  output logic                         light_cnt_last,
  output logic                         sec_tick,
  output logic [CNT_WIDTH-1:0]         sec_remain,
  output logic                         init_err
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [PRE_WIDTH-1:0]         PRE_MAX  = PRE_WIDTH'(CLK_PER_SEC - 1);
  localparam logic [PRE_WIDTH-1:0]         PRE_LAST = PRE_WIDTH'(CLK_PER_SEC - 2);
  localparam logic [LIGHT_STATE_WIDTH-1:0] ONE      = LIGHT_STATE_WIDTH'(1);

  state_t                       state;
  logic [PRE_WIDTH-1:0]         pre_cnt;
  logic [CNT_WIDTH-1:0]         light_cnt;
  logic [LIGHT_STATE_WIDTH-1:0] init_q;

  logic                 is_onehot;
  logic                 is_multi;
  logic                 load;
  logic [CNT_WIDTH-1:0] dur_m1;

  always_comb begin
    is_onehot = (light_cnt_init != '0) && ((light_cnt_init & (light_cnt_init - ONE)) == '0);
    is_multi  = (light_cnt_init != '0) && !is_onehot;
    // Only a change of light reloads; a steady one-hot select keeps counting.
    load      = is_onehot && (light_cnt_init != init_q);
    if (light_cnt_init[0])      dur_m1 = CNT_WIDTH'(GREEN_SEC - 1);
    else if (light_cnt_init[1]) dur_m1 = CNT_WIDTH'(YELLOW_SEC - 1);
    else                        dur_m1 = CNT_WIDTH'(RED_SEC - 1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      light_cnt <= '0;
      init_q    <= '0;
      init_err  <= 1'b0;
    end else if (!en) begin
      state     <= IDLE;
      pre_cnt   <= '0;
      light_cnt <= '0;
      init_q    <= '0;
      init_err  <= 1'b0;
    end else begin
      init_q <= light_cnt_init;
      if (is_multi) begin
        init_err  <= 1'b1;
        state     <= IDLE;
        pre_cnt   <= '0;
        light_cnt <= '0;
      end else if (load) begin
        state     <= RUN;
        pre_cnt   <= '0;
        light_cnt <= dur_m1;
      end else if (light_cnt_init == '0) begin
        state     <= IDLE;
        pre_cnt   <= '0;
        light_cnt <= '0;
      end else if (state == RUN) begin
        // Load normally lands on the wrap that would take light_cnt below 0.
        if (pre_cnt == PRE_MAX) begin
          pre_cnt <= '0;
          if (light_cnt != '0) light_cnt <= light_cnt - 1'b1;
        end else begin
          pre_cnt <= pre_cnt + 1'b1;
        end
      end
    end
  end

  assign second_cnt_pre_last = (state == RUN) && (pre_cnt == PRE_LAST);
  assign light_cnt_last      = (state == RUN) && (light_cnt == '0);
  assign sec_tick            = (state == RUN) && (pre_cnt == PRE_MAX);
  assign sec_remain          = (state == RUN) ? light_cnt + 1'b1 : '0;

endmodule
